// File: rtl/scazator_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package scazator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/semiscazator_complet.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module semiscazator_complet (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/scazator_serial.sv
// Bit-serial subtractor, LSB first, one bit per clock; result appears after WIDTH cycles.
// Define SCAZATOR_OVERFLOW_EN to add the signed-overflow output ovf.
module scazator_serial
  import scazator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SCAZATOR_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] res_reg;
  logic [WIDTH-1:0] res_full;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             d_bit, br_bit;
  logic             last_bit;

  semiscazator_complet u_bit (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (br_bit)
  );

  // res_reg holds the WIDTH-1 bits already computed; the current bit completes the word.
  assign res_full = {d_bit, res_reg};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
      br_reg  <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SCAZATOR_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          a_reg   <= a;
          b_reg   <= b;
          br_reg  <= 1'b0;
          cnt_reg <= '0;
        end
        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br_reg  <= br_bit;
          res_reg <= res_full[WIDTH-1:1];
          cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            diff <= res_full;
            bout <= br_bit;
`ifdef SCAZATOR_OVERFLOW_EN
            // On the last bit the shifted operands expose the original sign bits.
            ovf  <= (a_reg[0] ^ b_reg[0]) & (d_bit ^ a_reg[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/scazator_serial.md
SCAZATOR_SERIAL -- requirements
Module: scazator_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled with start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled with start.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-009 SHALL have port diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  final borrow out (1 when a < b unsigned).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 In IDLE, start=1 SHALL latch a and b into internal shift registers, clear the borrow flop and bit counter, and enter RUN.
REQ-013 In RUN, each cycle SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-014 SHALL shift d into the result register from the MSB end, so after WIDTH RUN cycles diff[0] holds the first bit computed.
REQ-015 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-018 diff and bout SHALL update only on the final RUN cycle and hold until the next accepted start completes.
REQ-019 start SHALL be ignored in RUN and DONE; a/b changes during RUN SHALL have no effect.
REQ-020 start held high continuously SHALL produce back-to-back operations, with one IDLE cycle between done and the next RUN.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow=0, ovf=0 (when present).
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the first start SHALL begin a clean operation.

Configuration
REQ-024 Macro SCAZATOR_OVERFLOW_EN defined SHALL add output port ovf (output, 1 bit): signed two's-complement overflow = (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]).
REQ-025 ovf SHALL update and hold together with diff.
REQ-026 Without SCAZATOR_OVERFLOW_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package/header scazator_pkg.
REQ-028 The per-bit logic SHALL be a combinational sub-module semiscazator_complet (a, b, bin -> d, bout), instantiated once.
REQ-029 All state, shift, counter and borrow registers SHALL be in scazator_serial.

Verification
REQ-030 WIDTH=8, a=0x35, b=0x12, start 1 cycle -> done 9 cycles later; diff=0x23, bout=0, ovf=0.
REQ-031 a=0x12, b=0x35 -> diff=0xDD, bout=1, ovf=0.
REQ-032 a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
REQ-033 Start a=0x35/b=0x12, then pulse start with a=0xFF/b=0xFF during RUN -> exactly one done, diff=0x23.
REQ-034 Start an operation, assert rst_n=0 at RUN cycle 4 -> all outputs 0 immediately, no done; then start a=0x10/b=0x01 -> diff=0x0F.
REQ-035 start held high for 3 operations -> done pulses spaced WIDTH+2 cycles apart, busy low exactly one cycle between them.
